// File: rtl/fir_filter_mac.sv
// Time-multiplexed direct-form FIR: one multiplier and accumulator, one tap per clock.
// Runtime-loadable coefficients, valid/ready sample input, saturating registered output.
//
// state  | meaning
// S_IDLE | ready for a sample; coefficient writes and clear honoured here
// S_MAC  | one tap product accumulated per cycle, idx 0..N_TAPS-1
// S_OUT  | o_y/o_sat just updated, o_valid high for this single cycle
module fir_filter_mac #(
    parameter int N_TAPS   = 4,
    parameter int DATA_W   = 3,
    parameter int COEF_W   = 8,
    parameter int SIGNED   = 0,
    parameter int OUT_W    = 12,
    parameter int COEF_RST = 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [DATA_W-1:0]         i_x,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_clr,
    input  logic                      i_coef_we,
    input  logic [$clog2(N_TAPS)-1:0] i_coef_addr,
    input  logic [COEF_W-1:0]         i_coef_data,
    output logic [OUT_W-1:0]          o_y,
    output logic                      o_valid,
    output logic                      o_sat
);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(N_TAPS);
    localparam int IDX_W = $clog2(N_TAPS);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [DATA_W-1:0]   r_x [N_TAPS];
    logic [COEF_W-1:0]   r_c [N_TAPS];
    logic [ACC_W-1:0]    r_acc;
    logic [IDX_W-1:0]    r_idx;
    logic [OUT_W-1:0]    r_y;
    logic                r_sat;
    logic                r_valid;
    logic                w_last;
    logic [ACC_W-1:0]    w_x_ext;
    logic [ACC_W-1:0]    w_c_ext;
    logic [ACC_W-1:0]    w_sum;
    logic [OUT_W-1:0]    w_y_sat;
    logic                w_sat;

    assign w_last  = (r_idx == IDX_W'(N_TAPS - 1));
    // Extending both operands to ACC_W keeps the low ACC_W product bits exact in either signedness.
    assign w_x_ext = {{(ACC_W-DATA_W){(SIGNED != 0) && r_x[r_idx][DATA_W-1]}}, r_x[r_idx]};
    assign w_c_ext = {{(ACC_W-COEF_W){(SIGNED != 0) && r_c[r_idx][COEF_W-1]}}, r_c[r_idx]};
    assign w_sum   = r_acc + w_x_ext * w_c_ext;

    generate
        if (OUT_W < ACC_W) begin : g_sat
            if (SIGNED != 0) begin : g_signed
                always_comb begin
                    w_sat   = !((&w_sum[ACC_W-1:OUT_W-1]) || !(|w_sum[ACC_W-1:OUT_W-1]));
                    w_y_sat = w_sum[OUT_W-1:0];
                    if (w_sat)
                        w_y_sat = w_sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                 : {1'b0, {(OUT_W-1){1'b1}}};
                end
            end else begin : g_unsigned
                always_comb begin
                    w_sat   = |w_sum[ACC_W-1:OUT_W];
                    w_y_sat = w_sat ? {OUT_W{1'b1}} : w_sum[OUT_W-1:0];
                end
            end
        end else begin : g_nosat
            assign w_sat   = 1'b0;
            assign w_y_sat = w_sum[OUT_W-1:0];
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (i_valid) w_next = S_MAC;
            S_MAC:   if (w_last)  w_next = S_OUT;
            S_OUT:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                r_x[k] <= '0;
                r_c[k] <= COEF_W'(COEF_RST);
            end
            r_acc   <= '0;
            r_idx   <= '0;
            r_y     <= '0;
            r_sat   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (r_state == S_IDLE) begin
                if (i_coef_we && (int'(i_coef_addr) < N_TAPS))
                    r_c[i_coef_addr] <= i_coef_data;
                if (i_clr)
                    for (int k = 0; k < N_TAPS; k++) r_x[k] <= '0;
                // Clear-with-accept: shift in zeros so only the new sample survives.
                if (i_valid) begin
                    for (int k = 1; k < N_TAPS; k++) r_x[k] <= i_clr ? '0 : r_x[k-1];
                    r_x[0] <= i_x;
                    r_acc  <= '0;
                    r_idx  <= '0;
                end
            end else if (r_state == S_MAC) begin
                r_acc <= w_sum;
                r_idx <= r_idx + IDX_W'(1);
                if (w_last) begin
                    r_y     <= w_y_sat;
                    r_sat   <= w_sat;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign o_ready = (r_state == S_IDLE);
    assign o_y     = r_y;
    assign o_sat   = r_sat;
    assign o_valid = r_valid;
endmodule

// File: doc/fir_filter_mac.md
Name: fir_filter_mac

Overview:
- Parametrised successor to the fixed 3-bit-in / 12-bit-out FIR filter.
- Time-multiplexed direct-form FIR: one multiplier plus accumulator, one tap per clock.
- Runtime-loadable coefficients, valid/ready input handshake, one-cycle output strobe, saturating output.
- Sits between the key-driven sample source and the bin2bcd/display path, all on the system clock instead of a key-derived clock.

Parameters:
- N_TAPS, 4: number of taps, 2..64.
- DATA_W, 3: input sample width.
- COEF_W, 8: coefficient width.
- SIGNED, 0: 0 treats samples, coefficients and result as unsigned; 1 as two's complement.
- OUT_W, 12: output width. Must be ≤ ACC_W, where ACC_W = DATA_W + COEF_W + clog2(N_TAPS).
- COEF_RST, 1: value loaded into every coefficient at reset.

Ports:
- i_clk, input, 1: system clock.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_x, input, DATA_W: input sample.
- i_valid, input, 1: sample offered.
- o_ready, output, 1: block can accept a sample.
- i_clr, input, 1: synchronous clear of the delay line.
- i_coef_we, input, 1: coefficient write strobe.
- i_coef_addr, input, clog2(N_TAPS): tap index for the write.
- i_coef_data, input, COEF_W: coefficient value.
- o_y, output, OUT_W: filter result.
- o_valid, output, 1: one-cycle pulse when o_y is updated.
- o_sat, output, 1: last result was clipped. Updated together with o_y.

Behaviour:
- Reset (asynchronous, active-low):
  - o_y=0, o_valid=0, o_sat=0, o_ready=1.
  - Delay line x[0..N_TAPS-1]=0; every c[k]=COEF_RST; accumulator=0; state IDLE.
- States: IDLE, MAC, OUT.
  - IDLE: o_ready=1. i_valid=1 accepts the sample (cycle t):
    - Shift: x[k] <= x[k-1] for k≥1, x[0] <= i_x.
    - Accumulator <= 0, tap index <= 0, go to MAC.
  - MAC: o_ready=0. Each cycle: accumulator += c[idx] × x[idx], idx++. After the idx=N_TAPS-1 product, go to OUT. Occupies cycles t+1 .. t+N_TAPS.
  - OUT: at cycle t+N_TAPS+1 register o_y and o_sat, pulse o_valid for exactly 1 cycle, return to IDLE. o_ready=0 in OUT.
- Latency and throughput:
  - Accept-to-o_valid latency is exactly N_TAPS+1 cycles.
  - Next accept is possible at t+N_TAPS+2 at the earliest. Max throughput is 1 sample per N_TAPS+2 cycles.
- Output between strobes: o_y and o_sat hold their value until the next o_valid.
- Arithmetic:
  - Products are COEF_W+DATA_W bits; the accumulator is ACC_W bits, so no internal overflow.
  - Products are signed or unsigned per SIGNED.
- Saturation (OUT_W < ACC_W):
  - The result is clipped to the OUT_W range: unsigned 0..2^OUT_W-1; signed -2^(OUT_W-1)..2^(OUT_W-1)-1.
  - o_sat=1 when clipping occurred, else 0.
  - If OUT_W = ACC_W, o_sat is always 0.
- Coefficient writes:
  - Honoured only in IDLE: c[i_coef_addr] <= i_coef_data.
  - Ignored in MAC and OUT (no side effect).
  - In IDLE, a write together with a sample accept is applied first, so the accepted sample's computation uses the new coefficient.
  - i_coef_addr ≥ N_TAPS is ignored.
- i_clr:
  - Honoured only in IDLE: zeroes x[] and leaves coefficients and o_y unchanged.
  - i_clr together with i_valid in IDLE: clear, then shift, so x[0]=i_x and all other x[k]=0.
  - i_clr in MAC or OUT is ignored.
- Handshake:
  - The sample is taken only when i_valid & o_ready.
  - i_valid held high during MAC/OUT waits; it is accepted on the first IDLE cycle.
  - i_x must be stable only in the accept cycle.
- Reset mid-operation (any state): immediate return to reset values. The in-flight result is discarded; no o_valid is issued.

Test Plan:
- Reset: hold i_rst_n=0 mid-run → o_y=0, o_valid=0, o_sat=0, o_ready=1. After release, impulse 1 gives o_y=1 (all c=COEF_RST=1).
- Impulse, default coefficients: samples 5,0,0,0,0 → o_y 5,5,5,5,0. Each o_valid occurs exactly 5 cycles after its accept, 1 cycle wide.
- Coefficient load: in IDLE write c=[1,2,3,4], then samples 1,0,0,0,0 → o_y 1,2,3,4,0. A write of c[0]=9 during MAC is ignored; the next impulse still yields 1.
- Saturation: c all 255, samples 7,7,7,7:
  - o_y 1785, 3570 with o_sat=0.
  - Then 4095 with o_sat=1, because 5355 is clipped.
  - Then 4095 with o_sat=1, because 7140 is clipped.
- Backpressure and clear:
  - i_valid held high continuously → accepts spaced exactly 6 cycles apart; o_ready=0 for 5 cycles after each accept.
  - i_clr with sample 2 after history 7,7,7 → o_y=2.
- Reset during MAC (cycle t+2): no o_valid follows. The delay line and coefficients are at reset values, verified by a following impulse 3 → o_y 3,3,3,3.
